// File: rtl/alu_sched_pkg.sv
// Shared types for the ALU operation scheduler: opcode encoding and FSM states.
package alu_sched_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_MUL = 2'd2,
        OP_XOR = 2'd3
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CONFIG = 2'd1,
        ST_EXEC   = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: lowest valid index at or above ptr wins,
// otherwise the search wraps to the lowest valid index overall.
module rr_arbiter #(
    parameter int N_REQ = 2,
    parameter int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] valid,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  index,
    output logic             any_valid
);

    logic [N_REQ-1:0] masked;
    logic [N_REQ-1:0] pick;

    always_comb begin
        masked    = '0;
        pick      = '0;
        grant     = '0;
        index     = '0;
        any_valid = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            masked[i] = valid[i] && (i >= int'(ptr));
        end
        // Requests below the pointer only compete when nothing at or above it is valid.
        pick = (|masked) ? masked : valid;
        for (int i = 0; i < N_REQ; i++) begin
            if (!any_valid && pick[i]) begin
                any_valid = 1'b1;
                grant[i]  = 1'b1;
                index     = ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/alu_op_scheduler.sv
// Shares one ALU between N_REQ requesters: round-robin grant, config write only
// on opcode change, single outstanding op returned on a tagged response channel.
//
//   state     | meaning
//   ST_IDLE   | arbitrate; grant handshake completes here, fields latched
//   ST_CONFIG | one-cycle ALU opcode write (config miss only)
//   ST_EXEC   | ALU config holds op; capture alu_c into the response register
//   ST_RESP   | hold response until resp_ready
module alu_op_scheduler
    import alu_sched_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int WIDTH = 16,
    localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [2*N_REQ-1:0]     req_op,
    input  logic [WIDTH*N_REQ-1:0] req_a,
    input  logic [WIDTH*N_REQ-1:0] req_b,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic [WIDTH-1:0]       resp_data,
    output logic [ID_W-1:0]        resp_id,
    output logic [WIDTH-1:0]       alu_a,
    output logic [WIDTH-1:0]       alu_b,
    input  logic [WIDTH-1:0]       alu_c,
    output logic [1:0]             alu_config_data,
    output logic                   alu_config_en,
    output logic [15:0]            op_count,
    output logic [15:0]            reconfig_count
);

    state_t            state_q, state_d;
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic              cfg_valid_q, cfg_valid_d;
    op_t               cfg_op_q, cfg_op_d;
    op_t               op_q, op_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [WIDTH-1:0]  resp_data_q, resp_data_d;
    logic [ID_W-1:0]   resp_id_q, resp_id_d;
    logic [15:0]       op_count_q, op_count_d;
    logic [15:0]       reconfig_count_q, reconfig_count_d;

    logic [N_REQ-1:0]  arb_grant;
    logic [ID_W-1:0]   arb_index;
    logic              arb_any;
    logic [N_REQ-1:0]  req_ready_c;
    logic              cfg_en_c;
    logic [1:0]        cfg_data_c;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_arb (
        .valid     (req_valid),
        .ptr       (rr_ptr_q),
        .grant     (arb_grant),
        .index     (arb_index),
        .any_valid (arb_any)
    );

    always_comb begin
        state_d          = state_q;
        rr_ptr_d         = rr_ptr_q;
        cfg_valid_d      = cfg_valid_q;
        cfg_op_d         = cfg_op_q;
        op_d             = op_q;
        a_d              = a_q;
        b_d              = b_q;
        id_d             = id_q;
        resp_data_d      = resp_data_q;
        resp_id_d        = resp_id_q;
        op_count_d       = op_count_q;
        reconfig_count_d = reconfig_count_q;
        req_ready_c      = '0;
        cfg_en_c         = 1'b0;
        cfg_data_c       = 2'b00;

        case (state_q)
            ST_IDLE: begin
                if (arb_any) begin
                    req_ready_c = arb_grant;
                    id_d        = arb_index;
                    for (int i = 0; i < N_REQ; i++) begin
                        if (arb_grant[i]) begin
                            op_d = op_t'(req_op[2*i +: 2]);
                            a_d  = req_a[WIDTH*i +: WIDTH];
                            b_d  = req_b[WIDTH*i +: WIDTH];
                        end
                    end
                    state_d = (cfg_valid_q && (op_d == cfg_op_q)) ? ST_EXEC : ST_CONFIG;
                end
            end
            ST_CONFIG: begin
                cfg_en_c         = 1'b1;
                cfg_data_c       = op_q;
                cfg_op_d         = op_q;
                cfg_valid_d      = 1'b1;
                reconfig_count_d = reconfig_count_q + 16'd1;
                state_d          = ST_EXEC;
            end
            ST_EXEC: begin
                resp_data_d = alu_c;
                resp_id_d   = id_q;
                state_d     = ST_RESP;
            end
            ST_RESP: begin
                if (resp_ready) begin
                    op_count_d = op_count_q + 16'd1;
                    rr_ptr_d   = (id_q == ID_W'(N_REQ - 1)) ? '0 : id_q + 1'b1;
                    state_d    = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q          <= ST_IDLE;
            rr_ptr_q         <= '0;
            cfg_valid_q      <= 1'b0;
            cfg_op_q         <= OP_ADD;
            op_q             <= OP_ADD;
            a_q              <= '0;
            b_q              <= '0;
            id_q             <= '0;
            resp_data_q      <= '0;
            resp_id_q        <= '0;
            op_count_q       <= '0;
            reconfig_count_q <= '0;
        end else begin
            state_q          <= state_d;
            rr_ptr_q         <= rr_ptr_d;
            cfg_valid_q      <= cfg_valid_d;
            cfg_op_q         <= cfg_op_d;
            op_q             <= op_d;
            a_q              <= a_d;
            b_q              <= b_d;
            id_q             <= id_d;
            resp_data_q      <= resp_data_d;
            resp_id_q        <= resp_id_d;
            op_count_q       <= op_count_d;
            reconfig_count_q <= reconfig_count_d;
        end
    end

    // Handshake and strobe outputs are masked while RESET is high so a reset
    // cycle can never complete a grant, a response or an ALU config write.
    assign req_ready       = req_ready_c & {N_REQ{~RESET}};
    assign resp_valid      = (state_q == ST_RESP) & ~RESET;
    assign alu_config_en   = cfg_en_c & ~RESET;
    assign alu_config_data = cfg_data_c;
    assign resp_data       = resp_data_q;
    assign resp_id         = resp_id_q;
    assign alu_a           = a_q;
    assign alu_b           = b_q;
    assign op_count        = op_count_q;
    assign reconfig_count  = reconfig_count_q;

endmodule

// File: tb/tb_alu_op_scheduler.sv
// Bench for alu_op_scheduler: behavioural SimpleALU attached to the ALU port,
// expected responses queued at request time and popped on response handshake.
module tb_alu_op_scheduler;

    localparam int N_REQ = 2;
    localparam int WIDTH = 16;

    logic                   CLK = 1'b0;
    logic                   RESET;
    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ-1:0]       req_ready;
    logic [2*N_REQ-1:0]     req_op;
    logic [WIDTH*N_REQ-1:0] req_a;
    logic [WIDTH*N_REQ-1:0] req_b;
    logic                   resp_valid;
    logic                   resp_ready;
    logic [WIDTH-1:0]       resp_data;
    logic [0:0]             resp_id;
    logic [WIDTH-1:0]       alu_a;
    logic [WIDTH-1:0]       alu_b;
    logic [WIDTH-1:0]       alu_c;
    logic [1:0]             alu_config_data;
    logic                   alu_config_en;
    logic [15:0]            op_count;
    logic [15:0]            reconfig_count;

    typedef struct packed {
        logic [15:0] data;
        logic [0:0]  id;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 CLK = ~CLK;

    alu_op_scheduler #(.N_REQ(N_REQ), .WIDTH(WIDTH)) dut (
        .CLK             (CLK),
        .RESET           (RESET),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_op          (req_op),
        .req_a           (req_a),
        .req_b           (req_b),
        .resp_valid      (resp_valid),
        .resp_ready      (resp_ready),
        .resp_data       (resp_data),
        .resp_id         (resp_id),
        .alu_a           (alu_a),
        .alu_b           (alu_b),
        .alu_c           (alu_c),
        .alu_config_data (alu_config_data),
        .alu_config_en   (alu_config_en),
        .op_count        (op_count),
        .reconfig_count  (reconfig_count)
    );

    // SimpleALU: registered opcode, combinational result, never reset by the scheduler.
    logic [1:0] alu_cfg = 2'd0;
    always @(posedge CLK) if (alu_config_en) alu_cfg <= alu_config_data;
    always_comb begin
        alu_c = '0;
        case (alu_cfg)
            2'd0: alu_c = alu_a + alu_b;
            2'd1: alu_c = alu_a - alu_b;
            2'd2: alu_c = WIDTH'(alu_a * alu_b);
            default: alu_c = alu_a ^ alu_b;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_req(input int i, input logic [1:0] op, input logic [15:0] a,
                           input logic [15:0] b);
        req_valid[i]           = 1'b1;
        req_op[2*i +: 2]       = op;
        req_a[WIDTH*i +: WIDTH] = a;
        req_b[WIDTH*i +: WIDTH] = b;
    endtask

    always @(negedge CLK) begin
        if (resp_valid && resp_ready) begin
            if (sb_q.size() == 0) begin
                check("unexpected_resp", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("sb_data", resp_data, e.data);
                check("sb_id", resp_id, e.id);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        RESET = 1'b1; req_valid = '0; req_op = '0; req_a = '0; req_b = '0; resp_ready = 1'b0;
        repeat (3) step();
        check("rst_req_ready", req_ready, 0);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_resp_data", resp_data, 0);
        check("rst_cfg_en", alu_config_en, 0);
        check("rst_alu_a", alu_a, 0);
        check("rst_op_count", op_count, 0);
        check("rst_reconfig", reconfig_count, 0);
        RESET = 1'b0;
        step();

        // First op after reset: config miss, resp at T+3
        set_req(0, 2'd0, 16'd3, 16'd5);
        resp_ready = 1'b1;
        sb_q.push_back('{16'd8, 1'b0});
        #1 check("t1_grant", req_ready, 2'b01);
        step(); req_valid = '0;
        check("t1_cfg_en", alu_config_en, 1);
        check("t1_cfg_data", alu_config_data, 0);
        check("t1_valid_t1", resp_valid, 0);
        step();
        check("t1_cfg_en_exec", alu_config_en, 0);
        check("t1_alu_a", alu_a, 3);
        check("t1_alu_b", alu_b, 5);
        check("t1_valid_t2", resp_valid, 0);
        step();
        check("t1_valid_t3", resp_valid, 1);
        check("t1_data", resp_data, 8);
        step();
        check("t1_reconfig", reconfig_count, 1);
        check("t1_op_count", op_count, 1);

        // Same opcode: config hit, resp at T+2
        set_req(0, 2'd0, 16'd10, 16'd4);
        sb_q.push_back('{16'd14, 1'b0});
        #1 check("t2_grant", req_ready, 2'b01);
        step(); req_valid = '0;
        check("t2_cfg_en", alu_config_en, 0);
        check("t2_valid_t1", resp_valid, 0);
        step();
        check("t2_valid_t2", resp_valid, 1);
        check("t2_data", resp_data, 14);
        step();
        check("t2_reconfig", reconfig_count, 1);
        check("t2_op_count", op_count, 2);

        // Contention with rr_ptr=1: requester 1 first, then requester 0
        set_req(0, 2'd2, 16'd300, 16'd300);
        set_req(1, 2'd3, 16'hFFFF, 16'h00FF);
        sb_q.push_back('{16'hFF00, 1'b1});
        sb_q.push_back('{16'h5F90, 1'b0});
        #1 check("t3_grant1", req_ready, 2'b10);
        step(); req_valid[1] = 1'b0;
        check("t3_cfg_en", alu_config_en, 1);
        check("t3_cfg_data", alu_config_data, 3);
        step(); step();
        check("t3_valid1", resp_valid, 1);
        check("t3_id1", resp_id, 1);
        step();
        check("t3_grant0", req_ready, 2'b01);
        step();
        check("t3_cfg_data0", alu_config_data, 2);
        // Back-pressure while requester 0 already holds a new SUB request
        resp_ready = 1'b0;
        set_req(0, 2'd1, 16'd2, 16'd5);
        sb_q.push_back('{16'hFFFD, 1'b0});
        step(); step();
        for (int k = 0; k < 5; k++) begin
            check("t4_valid", resp_valid, 1);
            check("t4_data", resp_data, 16'h5F90);
            check("t4_id", resp_id, 0);
            check("t4_req_ready", req_ready, 0);
            check("t4_cfg_en", alu_config_en, 0);
            step();
        end
        resp_ready = 1'b1;
        step();
        check("t4_op_count", op_count, 4);
        check("t4_reconfig", reconfig_count, 3);
        check("t5_grant", req_ready, 2'b01);
        step(); req_valid = '0;
        check("t5_cfg_en", alu_config_en, 1);
        check("t5_cfg_data", alu_config_data, 1);
        step(); step();
        check("t5_data", resp_data, 16'hFFFD);
        step();
        check("t5_op_count", op_count, 5);
        check("t5_reconfig", reconfig_count, 4);

        // Reset during CONFIG aborts the op; next XOR must reconfigure
        set_req(1, 2'd3, 16'h1234, 16'h00FF);
        #1 check("t6_grant", req_ready, 2'b10);
        step(); req_valid = '0;
        check("t6_cfg_en", alu_config_en, 1);
        check("t6_cfg_data", alu_config_data, 3);
        RESET = 1'b1;
        #1 check("t6_cfg_en_rst", alu_config_en, 0);
        step();
        RESET = 1'b0;
        #1;
        check("t6_resp_valid", resp_valid, 0);
        check("t6_resp_data", resp_data, 0);
        check("t6_resp_id", resp_id, 0);
        check("t6_alu_a", alu_a, 0);
        check("t6_alu_b", alu_b, 0);
        check("t6_cfg_en2", alu_config_en, 0);
        check("t6_cfg_data2", alu_config_data, 0);
        check("t6_op_count", op_count, 0);
        check("t6_reconfig", reconfig_count, 0);
        step(); step();
        check("t6_no_resp", resp_valid, 0);
        set_req(1, 2'd3, 16'h1234, 16'h00FF);
        sb_q.push_back('{16'h12CB, 1'b1});
        #1 check("t7_grant", req_ready, 2'b10);
        step(); req_valid = '0;
        check("t7_cfg_en", alu_config_en, 1);
        check("t7_cfg_data", alu_config_data, 3);
        step(); step();
        check("t7_valid", resp_valid, 1);
        check("t7_data", resp_data, 16'h12CB);
        step();
        check("t7_op_count", op_count, 1);
        check("t7_reconfig", reconfig_count, 1);
        step();
        check("sb_empty", sb_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
